// File: rtl/adex_pkg.sv
// Shared constants for the AdEx parameter sequencer: preset banks, parameter
// indices, footer nibble, FSM encoding and the token-to-nibble mapping.
package adex_pkg;

    // Byte i of a bank lives at [i]; index 0 is sent first.
    typedef logic [7:0][7:0] bank_t;

    localparam logic [2:0] IDX_DELTAT = 3'd0;
    localparam logic [2:0] IDX_TAUW   = 3'd1;
    localparam logic [2:0] IDX_A      = 3'd2;
    localparam logic [2:0] IDX_B      = 3'd3;
    localparam logic [2:0] IDX_VRESET = 3'd4;
    localparam logic [2:0] IDX_VT     = 3'd5;
    localparam logic [2:0] IDX_IBIAS  = 3'd6;
    localparam logic [2:0] IDX_C      = 3'd7;

    localparam bank_t BANK0_P = {8'd200, 8'd128, 8'd78, 8'd63, 8'd40, 8'd2, 8'd100, 8'd130};
    localparam bank_t BANK1_P = {8'd200, 8'd170, 8'd78, 8'd63, 8'd40, 8'd2, 8'd100, 8'd130};
    localparam bank_t BANK2_P = {8'd150, 8'd170, 8'd78, 8'd70, 8'd80, 8'd4, 8'd50, 8'd130};

    localparam logic [3:0] FOOTER_NIB = 4'hF;
    localparam logic [4:0] LAST_TOKEN = 5'd17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE_HI,
        ST_STROBE_LO,
        ST_HOLD,
        ST_DONE
    } seq_state_e;

    // Token 0 is the start strobe, 1..16 carry bytes high nibble first, 17 is the footer.
    function automatic logic [3:0] token_nibble(input bank_t snap, input logic [4:0] k);
        logic [7:0] b;
        b = snap[3'((k - 5'd1) >> 1)];
        if (k == 5'd0)
            return 4'h0;
        else if (k == LAST_TOKEN)
            return FOOTER_NIB;
        else if (k[0])
            return b[7:4];
        else
            return b[3:0];
    endfunction

endpackage

// File: rtl/adex_param_bank.sv
// Parameter bank store: three constant presets plus the user-writable bank 3,
// with a combinational bank-select read port.
module adex_param_bank
    import adex_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [1:0] bank_sel,
    output bank_t      rd_bank
);

    bank_t bank3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bank3_q <= BANK0_P;
        else if (wr_en)
            bank3_q[wr_addr] <= wr_data;
    end

    // Reads see the pre-write contents, so a write coinciding with start misses that run.
    always_comb begin
        rd_bank = BANK0_P;
        case (bank_sel)
            2'd0: rd_bank = BANK0_P;
            2'd1: rd_bank = BANK1_P;
            2'd2: rd_bank = BANK2_P;
            2'd3: rd_bank = bank3_q;
            default: rd_bank = BANK0_P;
        endcase
    end

endmodule

// File: rtl/adex_param_sequencer.sv
// Autonomous nibble-serial parameter loader driver for the AdEx neuron core:
// snapshots a bank and emits start strobe, 16 data nibbles and footer.
module adex_param_sequencer
    import adex_pkg::*;
#(
    parameter int unsigned STROBE_HI   = 1,
    parameter int unsigned STROBE_LO   = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter bit          AUTO_LOAD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] bank_sel,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       load_mode,
    output logic       load_enable,
    output logic [3:0] nibble,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam logic [7:0] HI_LAST   = 8'(STROBE_HI - 1);
    localparam logic [7:0] LO_LAST   = 8'(STROBE_LO - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    seq_state_e state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [4:0] tok_q, tok_d;
    bank_t      snap_q, rd_bank;
    logic       snap_ld;
    logic       aborted_q, aborted_d;
    logic       launched_q;
    logic       auto_go, launch, active;
    logic [1:0] rd_sel;

    // Auto-load fires once, on the first edge after reset release.
    assign auto_go = AUTO_LOAD && !launched_q;
    assign launch  = (start || auto_go) && !abort;
    assign rd_sel  = auto_go ? 2'd0 : bank_sel;
    assign active  = (state_q == ST_SETUP) || (state_q == ST_STROBE_HI) ||
                     (state_q == ST_STROBE_LO) || (state_q == ST_HOLD);

    adex_param_bank u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bank_sel (rd_sel),
        .rd_bank  (rd_bank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            tok_q      <= '0;
            snap_q     <= '0;
            aborted_q  <= 1'b0;
            launched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tok_q      <= tok_d;
            aborted_q  <= aborted_d;
            launched_q <= 1'b1;
            if (snap_ld)
                snap_q <= rd_bank;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        tok_d     = tok_q;
        snap_ld   = 1'b0;
        aborted_d = 1'b0;
        if (active && abort) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_d = ST_SETUP;
                        snap_ld = 1'b1;
                        phase_d = '0;
                        tok_d   = '0;
                    end
                end
                ST_SETUP: begin
                    state_d = ST_STROBE_HI;
                    phase_d = '0;
                end
                ST_STROBE_HI: begin
                    if (phase_q == HI_LAST) begin
                        state_d = ST_STROBE_LO;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                // Token advances only here, so nibble changes with the rising strobe.
                ST_STROBE_LO: begin
                    if (phase_q == LO_LAST) begin
                        phase_d = '0;
                        if (tok_q == LAST_TOKEN) begin
                            state_d = ST_HOLD;
                        end else begin
                            tok_d   = tok_q + 5'd1;
                            state_d = ST_STROBE_HI;
                        end
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (phase_q == HOLD_LAST) begin
                        state_d = ST_DONE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state so async reset clears them at once.
    assign load_mode   = active;
    assign busy        = active;
    assign load_enable = (state_q == ST_STROBE_HI);
    assign done        = (state_q == ST_DONE);
    assign aborted     = aborted_q;
    assign nibble      = ((state_q == ST_STROBE_HI) || (state_q == ST_STROBE_LO) ||
                          (state_q == ST_HOLD)) ? token_nibble(snap_q, tok_q) : 4'h0;

endmodule

// File: tb/tb_adex_param_sequencer.sv
// Self-checking bench for adex_param_sequencer: table-driven bank runs with a
// nibble scoreboard, plus abort, back-to-back, auto-load and async-reset sequences.
module tb_adex_param_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, wr_en;
    logic [1:0] bank_sel;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       load_mode, load_enable, busy, done, aborted;
    logic [3:0] nibble;

    logic       rst2_n;
    logic       a_lm, a_le, a_busy, a_done, a_ab;
    logic [3:0] a_nib;

    int checks = 0;
    int failures = 0;

    logic [3:0] sb[$];
    int         le_edges = 0;
    logic       le_prev = 1'b0;
    logic [7:0] mdl[4][8];
    logic [3:0] auto_exp[18];
    int         a_edges = 0;
    logic       a_le_prev = 1'b0;

    typedef struct {
        logic       pre_w;
        logic [2:0] pre_a;
        logic [7:0] pre_d;
        logic [1:0] bs;
        logic       same_w;
        logic [2:0] same_a;
        logic [7:0] same_d;
        int         exp_done;
        int         exp_edges;
    } vec_t;
    vec_t vecs[6];

    adex_param_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bank_sel(bank_sel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_mode(load_mode), .load_enable(load_enable), .nibble(nibble),
        .busy(busy), .done(done), .aborted(aborted)
    );

    adex_param_sequencer #(.AUTO_LOAD(1'b1)) dut_auto (
        .clk(clk), .rst_n(rst2_n), .start(1'b0), .abort(1'b0), .bank_sel(2'b00),
        .wr_en(1'b0), .wr_addr(3'b000), .wr_data(8'h00),
        .load_mode(a_lm), .load_enable(a_le), .nibble(a_nib),
        .busy(a_busy), .done(a_done), .aborted(a_ab)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input int b);
        sb.push_back(4'h0);
        for (int i = 0; i < 8; i++) begin
            sb.push_back(mdl[b][i][7:4]);
            sb.push_back(mdl[b][i][3:0]);
        end
        sb.push_back(4'hF);
    endtask

    // Scoreboard: each load_enable rising edge must carry the next expected nibble.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && load_enable && !le_prev) begin
            le_edges++;
            if (sb.size() == 0)
                check("nibble_unexpected_strobe", {28'd0, nibble}, 32'hDEAD);
            else
                check("nibble", {28'd0, nibble}, {28'd0, sb.pop_front()});
        end
        le_prev = load_enable;
    end

    always @(negedge clk) begin
        if (rst2_n === 1'b1 && a_le && !a_le_prev) begin
            if (a_edges < 18)
                check("auto_nibble", {28'd0, a_nib}, {28'd0, auto_exp[a_edges]});
            a_edges++;
        end
        a_le_prev = a_le;
    end

    task automatic wait_done(output int got, output int busy_n);
        int n;
        n = 0;
        got = -1;
        busy_n = 0;
        while (got < 0 && n < 300) begin
            @(negedge clk);
            if (done) got = n;
            else begin
                if (busy) busy_n++;
                n++;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int got, busy_n;
        if (v.pre_w) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = v.pre_a; wr_data = v.pre_d;
            @(posedge clk); #1;
            wr_en = 1'b0;
            mdl[3][v.pre_a] = v.pre_d;
        end
        @(negedge clk);
        bank_sel = v.bs; start = 1'b1;
        wr_en = v.same_w; wr_addr = v.same_a; wr_data = v.same_d;
        le_edges = 0;
        push_stream(v.bs);
        if (v.same_w) mdl[3][v.same_a] = v.same_d;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        wait_done(got, busy_n);
        check("done_cycle", got, v.exp_done);
        check("busy_cycles", busy_n, v.exp_done);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("strobe_edges", le_edges, v.exp_edges);
        check("sb_empty", sb.size(), 0);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, load_mode}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, busy_n, gap;
        mdl[0] = '{8'd130, 8'd100, 8'd2, 8'd40, 8'd63, 8'd78, 8'd128, 8'd200};
        mdl[1] = '{8'd130, 8'd100, 8'd2, 8'd40, 8'd63, 8'd78, 8'd170, 8'd200};
        mdl[2] = '{8'd130, 8'd50,  8'd4, 8'd80, 8'd70, 8'd78, 8'd170, 8'd150};
        mdl[3] = mdl[0];
        auto_exp[0] = 4'h0;
        for (int i = 0; i < 8; i++) begin
            auto_exp[1 + 2*i] = mdl[0][i][7:4];
            auto_exp[2 + 2*i] = mdl[0][i][3:0];
        end
        auto_exp[17] = 4'hF;

        vecs[0] = '{1'b0, 3'd0, 8'h00, 2'd0, 1'b0, 3'd0, 8'h00, 59, 18};
        vecs[1] = '{1'b0, 3'd0, 8'h00, 2'd1, 1'b0, 3'd0, 8'h00, 59, 18};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 2'd2, 1'b0, 3'd0, 8'h00, 59, 18};
        vecs[3] = '{1'b1, 3'd6, 8'hA5, 2'd3, 1'b0, 3'd0, 8'h00, 59, 18};
        vecs[4] = '{1'b0, 3'd0, 8'h00, 2'd3, 1'b1, 3'd0, 8'h11, 59, 18};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 2'd3, 1'b0, 3'd0, 8'h00, 59, 18};

        rst_n = 1'b1; rst2_n = 1'b1;
        start = 1'b0; abort = 1'b0; wr_en = 1'b0;
        bank_sel = 2'd0; wr_addr = 3'd0; wr_data = 8'd0;
        #1;
        rst_n = 1'b0; rst2_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_load_mode", {31'd0, load_mode}, 32'd0);
        check("rst_load_enable", {31'd0, load_enable}, 32'd0);
        check("rst_nibble", {28'd0, nibble}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_aborted", {31'd0, aborted}, 32'd0);
        check("rst_auto_outs", {27'd0, a_lm, a_le, a_busy, a_done, a_ab}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", {30'd0, busy, load_mode}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort while k=9 sits in STROBE_LO.
        @(negedge clk);
        bank_sel = 2'd2; start = 1'b1;
        le_edges = 0;
        push_stream(2);
        while (sb.size() > 10) void'(sb.pop_back());
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        check("pre_abort_lo", {30'd0, load_mode, load_enable}, 32'd2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_load_mode", {31'd0, load_mode}, 32'd0);
        check("abort_pulse", {31'd0, aborted}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_outs", {27'd0, load_enable, nibble}, 32'd0);
        @(posedge clk); #1;
        check("abort_pulse_end", {31'd0, aborted}, 32'd0);
        check("abort_edges", le_edges, 10);
        check("abort_sb_empty", sb.size(), 0);

        // start and abort together in IDLE: nothing happens.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {29'd0, busy, load_mode, aborted}, 32'd0);
        @(negedge clk);
        check("start_abort_idle2", {30'd0, busy, load_mode}, 32'd0);

        // start held high: two runs separated by exactly two load_mode-low cycles.
        @(negedge clk);
        bank_sel = 2'd1; start = 1'b1;
        le_edges = 0;
        push_stream(1);
        push_stream(1);
        @(posedge clk); #1;
        wait_done(got, busy_n);
        check("b2b_done1", got, 59);
        gap = 0;
        while (!load_mode && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", gap, 2);
        start = 1'b0;
        wait_done(got, busy_n);
        check("b2b_done2", got, 58);
        check("b2b_edges", le_edges, 36);
        check("b2b_sb_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        check("b2b_no_third", {30'd0, busy, load_mode}, 32'd0);

        // Auto-load after reset release, then async reset mid-stream.
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        check("auto_setup", {29'd0, a_lm, a_busy, a_le}, 32'd6);
        repeat (20) @(posedge clk);
        #2;
        rst2_n = 1'b0;
        #1;
        check("async_rst_outs", {25'd0, a_lm, a_le, a_busy, a_nib}, 32'd0);
        check("auto_edges", a_edges, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
